// File: rtl/ppa_pkg.sv
// Shared definitions for the pipelined parallel-prefix adder second stage:
// default operand width, the prefix combine operator and the S1 payload layout.
package ppa_pkg;

    localparam int unsigned PPA_WIDTH = 4;

    // Combine a higher (gh,ph) group with the adjacent lower (gl,pl) group; returns {G,P}.
    function automatic logic [1:0] prefix_op(input logic gh, input logic ph,
                                             input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    // S1 payload at the default width; gg/pp hold the [i:0] group prefixes.
    typedef struct packed {
        logic [PPA_WIDTH-1:0] h;
        logic                 eac;
        logic                 cin_eff;
        logic [PPA_WIDTH-1:0] gg;
        logic [PPA_WIDTH-1:0] pp;
    } ppa_s1_t;

endpackage

// File: rtl/ppa_prefix_tree.sv
// Combinational Kogge-Stone prefix network: for every bit i, produces the
// group generate/propagate of the span [i:0].
module ppa_prefix_tree
    import ppa_pkg::*;
#(
    parameter int unsigned WIDTH  = PPA_WIDTH,
    parameter int unsigned LEVELS = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] gg,
    output logic [WIDTH-1:0] pp
);

    logic [LEVELS:0][WIDTH-1:0] gs;
    logic [LEVELS:0][WIDTH-1:0] ps;

    assign gs[0] = g;
    assign ps[0] = p;

    // Level l merges each bit with the group 2^l positions below; lower bits are already complete.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_op
                assign {gs[l+1][i], ps[l+1][i]} =
                    prefix_op(gs[l][i], ps[l][i], gs[l][i-(1<<l)], ps[l][i-(1<<l)]);
            end else begin : g_pass
                assign gs[l+1][i] = gs[l][i];
                assign ps[l+1][i] = ps[l][i];
            end
        end
    end

    assign gg = gs[LEVELS];
    assign pp = ps[LEVELS];

endmodule

// File: rtl/ppa_prefix_pipe.sv
// Two-stage prefix carry pipeline: S1 registers the prefix tree result and the
// effective carry-in, S2 registers sum/cout. Supports plain and end-around-carry add.
module ppa_prefix_pipe
    import ppa_pkg::*;
#(
    parameter  int unsigned WIDTH  = PPA_WIDTH,
    localparam int unsigned LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] h,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             cin,
    input  logic             eac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef struct packed {
        logic [WIDTH-1:0] h;
        logic             eac;
        logic             cin_eff;
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;
    } s1_payload_t;

    logic [WIDTH-1:0] tree_gg;
    logic [WIDTH-1:0] tree_pp;
    s1_payload_t      s1_d;
    s1_payload_t      s1_q;
    logic             v1;
    logic             v2;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    ppa_prefix_tree #(
        .WIDTH  (WIDTH),
        .LEVELS (LEVELS)
    ) u_tree (
        .g  (g),
        .p  (p),
        .gg (tree_gg),
        .pp (tree_pp)
    );

    assign s1_adv   = v1 && (!v2 || out_ready);
    assign in_ready = !v1 || s1_adv;
    assign accept   = in_valid && in_ready;

    // In end-around mode the carry-in is the full-width group generate.
    always_comb begin
        s1_d.h       = h;
        s1_d.eac     = eac;
        s1_d.cin_eff = eac ? tree_gg[WIDTH-1] : cin;
        s1_d.gg      = tree_gg;
        s1_d.pp      = tree_pp;
    end

    always_comb begin
        carry    = '0;
        carry[0] = s1_q.cin_eff;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i+1] = s1_q.gg[i] | (s1_q.pp[i] & s1_q.cin_eff);
        end
        sum_d  = s1_q.h ^ carry[WIDTH-1:0];
        cout_d = s1_q.eac ? s1_q.gg[WIDTH-1] : carry[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else begin
            v1 <= accept || (v1 && !s1_adv);
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            v2 <= s1_adv || (v2 && !out_ready);
            if (s1_adv) begin
                sum  <= sum_d;
                cout <= cout_d;
            end
        end
    end

    assign out_valid = v2;

endmodule
